// File: rtl/pulse_cross_rx.sv
// ---------------------------------------------------------------------------
// pulse_cross_rx
//
// Destination-side responder of an asynchronous 4-phase req/ack pulse
// crossing. The foreign-domain request level is synchronized into clk, and
// ack_a is returned to the source. Each completed request becomes one queued
// event. Queued events are issued as single-cycle imp_b pulses while out_en
// is high, with at least GAP idle cycles after each pulse.
//
// Ports:
//   clk      in   destination clock
//   rst      in   synchronous active-high reset
//   req_a    in   asynchronous request level from the source domain
//   ack_a    out  registered acknowledge level back to the source domain
//   out_en   in   permits issue of queued pulses
//   imp_b    out  registered single-cycle event pulse
//   pending  out  queued events not yet issued (saturates at 2^CNT_W-1)
//   ovf      out  sticky flag: an event was dropped because the queue was full
//   busy     out  high while the handshake FSM is not in IDLE
//
// Build option:
//   PULSE_CROSS_SYNC3_EN  when defined, a 3-stage synchronizer is used and
//                         every request-related latency grows by one edge.
// ---------------------------------------------------------------------------
module pulse_cross_rx #(
    parameter int CNT_W = 4,
    parameter int GAP_W = 8,
    parameter int GAP   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    output logic             ack_a,
    input  logic             out_en,
    output logic             imp_b,
    output logic [CNT_W-1:0] pending,
    output logic             ovf,
    output logic             busy
);

`ifdef PULSE_CROSS_SYNC3_EN
    localparam int SYNC_N = 3;
`else
    localparam int SYNC_N = 2;
`endif

    localparam logic [CNT_W-1:0] PEND_MAX = '1;
    localparam logic [GAP_W-1:0] GAP_LD   = GAP_W'(GAP);

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_IDLE = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Synchronizer chain. Deliberately outside rst so that a request level
    // held across reset is still seen as high afterwards; ARM then waits for
    // it to drop instead of counting it a second time.
    logic [SYNC_N-1:0] sync_q = '0;
    logic [SYNC_N-1:0] sync_d;
    logic              req_s;

    always_comb begin
        sync_d = {sync_q[SYNC_N-2:0], req_a};
    end

    always_ff @(posedge clk) begin
        sync_q <= sync_d;
    end

    assign req_s = sync_q[SYNC_N-1];

    // Handshake FSM, event queue and spacing counter.
    state_t           state_q, state_d;
    logic             ack_q, ack_d;
    logic             imp_q, imp_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             accept;
    logic             issue;

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        gap_d   = gap_q;
        imp_d   = 1'b0;
        accept  = 1'b0;
        issue   = (pend_q != '0) && out_en && (gap_q == '0);

        case (state_q)
            ST_ARM: begin
                ack_d = 1'b0;
                if (!req_s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                ack_d = 1'b0;
                if (req_s) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    accept  = 1'b1;
                end
            end
            ST_ACK: begin
                ack_d = 1'b1;
                if (!req_s) begin
                    state_d = ST_IDLE;
                    ack_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_ARM;
                ack_d   = 1'b0;
            end
        endcase

        // The spacing counter runs regardless of out_en so a long disable
        // period already satisfies the gap when issue resumes.
        if (issue) begin
            imp_d = 1'b1;
            gap_d = GAP_LD;
        end else if (gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end

        // An issue on the same edge frees a slot, so a full queue still
        // takes the new event and the count stays put.
        if (accept && !issue) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (issue && !accept) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ARM;
            ack_q   <= 1'b0;
            imp_q   <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            imp_q   <= imp_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            gap_q   <= gap_d;
        end
    end

    assign ack_a   = ack_q;
    assign imp_b   = imp_q;
    assign pending = pend_q;
    assign ovf     = ovf_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pulse_cross_rx.sv
// ---------------------------------------------------------------------------
// tb_pulse_cross_rx
//
// Bench for pulse_cross_rx. The main instance (default parameters) is
// tracked every cycle by a behavioural model built on protocol rules:
// a delayed view of req_a, an "armed once seen low" flag, a saturating
// integer queue and an earliest-next-issue timestamp. A second instance
// with GAP=0 covers back-to-back issue with literal expectations.
// ---------------------------------------------------------------------------
module tb_pulse_cross_rx;

`ifdef PULSE_CROSS_SYNC3_EN
    localparam int SYNC = 3;
`else
    localparam int SYNC = 2;
`endif
    localparam int CNT_W = 4;
    localparam int GAP   = 3;
    localparam int MAXP  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst, req_a, out_en;
    logic             ack_a, imp_b, ovf, busy;
    logic [CNT_W-1:0] pending;

    logic             rst0, req0, en0;
    logic             ack0, imp0, ovf0, busy0;
    logic [CNT_W-1:0] pending0;

    int n_checks = 0;
    int n_fail   = 0;

    pulse_cross_rx #(.CNT_W(CNT_W), .GAP_W(8), .GAP(GAP)) dut (
        .clk    (clk),
        .rst    (rst),
        .req_a  (req_a),
        .ack_a  (ack_a),
        .out_en (out_en),
        .imp_b  (imp_b),
        .pending(pending),
        .ovf    (ovf),
        .busy   (busy)
    );

    pulse_cross_rx #(.CNT_W(CNT_W), .GAP_W(8), .GAP(0)) dut0 (
        .clk    (clk),
        .rst    (rst0),
        .req_a  (req0),
        .ack_a  (ack0),
        .out_en (en0),
        .imp_b  (imp0),
        .pending(pending0),
        .ovf    (ovf0),
        .busy   (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the main instance ---------------
    bit m_hist[SYNC];      // m_hist[0] newest sample of req_a
    bit m_armed, m_ack, m_ovf, m_imp;
    int m_pend, m_next_ok, cyc;

    initial begin
        for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;
        m_armed = 0; m_ack = 0; m_ovf = 0; m_imp = 0;
        m_pend = 0; m_next_ok = 0; cyc = 0;
    end

    always @(posedge clk) begin
        bit rs, ack_n, iss, acc;
        rs = m_hist[SYNC-1];
        if (rst) begin
            m_armed   = 0;
            m_ack     = 0;
            m_pend    = 0;
            m_ovf     = 0;
            m_imp     = 0;
            m_next_ok = cyc;
        end else begin
            // acknowledge follows the synchronized level, but only once the
            // level has been seen low since reset
            iss     = (m_pend > 0) && out_en && (cyc >= m_next_ok);
            ack_n   = m_armed && rs;
            acc     = ack_n && !m_ack;
            m_armed = m_armed || !rs;
            m_ack   = ack_n;
            m_imp   = iss;
            if (iss) m_next_ok = cyc + GAP + 1;
            if (acc && !iss && m_pend == MAXP) m_ovf = 1;
            else m_pend = m_pend + (acc ? 1 : 0) - (iss ? 1 : 0);
        end
        for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = req_a;
        cyc++;
    end

    // ---------------- per-cycle compare and pulse bookkeeping -------------
    int pulses = 0;
    int pulse_t[$];

    always @(posedge clk) begin
        #1;
        chk("m_ack",  ack_a,   m_ack);
        chk("m_imp",  imp_b,   m_imp);
        chk("m_pend", pending, m_pend);
        chk("m_ovf",  ovf,     m_ovf);
        chk("m_busy", busy,    !(m_armed && !m_ack));
        if (imp_b === 1'b1) begin
            pulses++;
            pulse_t.push_back(cyc);
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic wait_ack(input logic lvl);
        int n = 0;
        while (ack_a !== lvl && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ack_wait", ack_a, lvl);
    endtask

    task automatic handshake();
        req_a = 1'b1;
        @(negedge clk);
        wait_ack(1'b1);
        req_a = 1'b0;
        @(negedge clk);
        wait_ack(1'b0);
        @(negedge clk);
    endtask

    task automatic hs0();
        int n = 0;
        req0 = 1'b1;
        while (ack0 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("ack0_hi", ack0, 1'b1);
        req0 = 1'b0;
        n = 0;
        while (ack0 !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        chk("ack0_lo", ack0, 1'b0);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic en);
        rst = 1'b1;
        out_en = en;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst = 1'b1; req_a = 1'b0; out_en = 1'b0;
        rst0 = 1'b1; req0 = 1'b0; en0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ack",  ack_a,   0);
        chk("rst_imp",  imp_b,   0);
        chk("rst_pend", pending, 0);
        chk("rst_ovf",  ovf,     0);
        chk("rst_busy", busy,    1);

        // 1: single event latency
        do_reset(1'b1);
        req_a = 1'b1;
        for (int k = 0; k <= SYNC + 2; k++) begin
            @(negedge clk);
            chk("t1_ack", ack_a, (k >= SYNC) ? 1 : 0);
            chk("t1_imp", imp_b, (k == SYNC + 1) ? 1 : 0);
        end
        req_a = 1'b0;
        for (int k = 0; k <= SYNC; k++) begin
            @(negedge clk);
            chk("t1_deassert", ack_a, (k < SYNC) ? 1 : 0);
        end
        chk("t1_pend", pending, 0);

        // 2: request held through reset is discarded
        rst = 1'b1; req_a = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        p0 = pulses;
        repeat (8) @(negedge clk);
        chk("t2_ack_held", ack_a, 0);
        chk("t2_busy_arm", busy, 1);
        chk("t2_no_pulse", pulses - p0, 0);
        req_a = 1'b0;
        repeat (4) @(negedge clk);
        chk("t2_busy_idle", busy, 0);
        handshake();
        repeat (8) @(negedge clk);
        chk("t2_one_pulse", pulses - p0, 1);

        // 3: queued events drained with spacing GAP+1
        do_reset(1'b0);
        p0 = pulses;
        repeat (5) handshake();
        repeat (3) @(negedge clk);
        chk("t3_pend5", pending, 5);
        chk("t3_held", pulses - p0, 0);
        pulse_t.delete();
        out_en = 1'b1;
        repeat (30) @(negedge clk);
        chk("t3_count", pulse_t.size(), 5);
        for (int i = 1; i < pulse_t.size(); i++)
            chk("t3_spacing", pulse_t[i] - pulse_t[i-1], GAP + 1);
        chk("t3_pend0", pending, 0);

        // 4: overflow is sticky
        do_reset(1'b0);
        repeat (15) handshake();
        chk("t4_pend15", pending, 15);
        chk("t4_ovf0", ovf, 0);
        handshake();
        chk("t4_pend_sat", pending, 15);
        chk("t4_ovf1", ovf, 1);
        out_en = 1'b1;
        repeat (3) handshake();
        repeat (80) @(negedge clk);
        chk("t4_drained", pending, 0);
        chk("t4_ovf_sticky", ovf, 1);
        do_reset(1'b0);
        chk("t4_ovf_cleared", ovf, 0);

        // 5: accept coinciding with issue while full
        repeat (15) handshake();
        chk("t5_pend15", pending, 15);
        req_a = 1'b1;
        repeat (SYNC) @(negedge clk);
        out_en = 1'b1;
        @(negedge clk);
        chk("t5_imp", imp_b, 1);
        chk("t5_ack", ack_a, 1);
        chk("t5_pend", pending, 15);
        chk("t5_ovf", ovf, 0);
        out_en = 1'b0;
        req_a = 1'b0;
        @(negedge clk);
        wait_ack(1'b0);
        repeat (2) @(negedge clk);
        chk("t5_ovf_after", ovf, 0);

        // 6: GAP=0 back-to-back pulses on the second instance
        rst0 = 1'b0;
        repeat (3) @(negedge clk);
        repeat (3) hs0();
        repeat (3) @(negedge clk);
        chk("t6_pend3", pending0, 3);
        en0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_imp", imp0, (k < 3) ? 1 : 0);
            chk("t6_pend", pending0, (k < 3) ? (2 - k) : 0);
        end
        chk("t6_ovf", ovf0, 0);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
